fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter TRAP_VECTOR, 32'h0000_0100, fetch address on trap.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 imem_req  out  1  instruction-memory request.
REQ-006 imem_addr  out  32  fetch address; equals internal pc.
REQ-007 imem_ack  in  1  one-cycle response strobe; imem_rdata valid with it.
REQ-008 imem_rdata  in  32  fetched instruction word.
REQ-009 inst_valid  out  1  inst/inst_pc hold a valid instruction for decode.
REQ-010 inst  out  32  instruction to decode.
REQ-011 inst_pc  out  32  address of inst.
REQ-012 dec_ready  in  1  decode consumes inst when inst_valid & dec_ready at a posedge.
REQ-013 redirect_valid  in  1  branch/jump taken this cycle.
REQ-014 redirect_pc  in  32  branch/jump target.
REQ-015 trap_valid  in  1  exception taken; target TRAP_VECTOR.
REQ-016 misalign_err  out  1  one-cycle pulse on misaligned redirect target.

Function
REQ-017 States IDLE, FETCH, STALL, DRAIN; 2-bit encoded register.
REQ-018 imem_req SHALL be 1 in FETCH and DRAIN, 0 in IDLE and STALL; imem_addr SHALL stay stable while imem_req is high until imem_ack.
REQ-019 IDLE -> FETCH unconditionally on the first posedge after rst deasserts.
REQ-020 FETCH, imem_ack, no flush: output slot free (inst_valid=0 or dec_ready=1) -> load inst/inst_pc, inst_valid=1 next cycle, pc<=pc+4, stay FETCH.
REQ-021 FETCH, imem_ack, slot busy (inst_valid=1, dec_ready=0) -> word and pc into 1-entry skid, pc<=pc+4, go STALL.
REQ-022 STALL: on dec_ready, skid -> output slot, go FETCH.
REQ-023 Throughput: zero-wait memory (ack same cycle as req) SHALL sustain one instruction per cycle; ack-to-inst_valid latency one cycle.
REQ-024 Flush = trap_valid | redirect_valid; target = TRAP_VECTOR if trap_valid, else redirect_pc (trap wins when simultaneous).
REQ-025 Flush SHALL clear inst_valid and the skid at the same posedge, regardless of dec_ready.
REQ-026 Flush in FETCH with imem_ack high, or in IDLE/STALL: pc<=target, next state FETCH, response discarded.
REQ-027 Flush in FETCH with imem_ack low: target into pend_pc, go DRAIN.
REQ-028 DRAIN: hold old address/request; on imem_ack discard data, pc<=pend_pc, go FETCH; a further flush in DRAIN overwrites pend_pc.
REQ-029 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 0) without error.
REQ-030 Flush has priority over capture; a flush cycle never produces inst_valid.

Reset
REQ-031 rst=0 SHALL immediately force state=IDLE, pc=RESET_VECTOR, pend_pc=0, inst_valid=0, inst=0, inst_pc=0, skid empty, misalign_err=0, imem_req=0.
REQ-032 Reset asserted mid-fetch SHALL abandon the outstanding request; an ack arriving during or after reset in IDLE is ignored.
REQ-033 After deassertion, first imem_req SHALL appear one cycle later with imem_addr=RESET_VECTOR.

Configuration
REQ-034 Macro FETCH_CTRL_MISALIGN_CHK_EN defined: redirect_pc[1:0]!=0 (trap_valid=0) SHALL redirect to TRAP_VECTOR and pulse misalign_err for one cycle.
REQ-035 Macro undefined: redirect_pc[1:0] forced to 2'b00, misalign_err tied 0, no check logic.

Verification
REQ-036 Reset release, zero-wait memory, dec_ready=1 -> addrs 0x0,0x4,0x8 on consecutive cycles, inst_valid continuous from cycle 2.
REQ-037 dec_ready=0 for 3 cycles with ack at 0x8 -> STALL, imem_req low, inst@0x4 held; dec_ready=1 -> inst@0x8 next, fetch resumes at 0xC.
REQ-038 Memory with 3-cycle ack, redirect_valid to 0x200 one cycle after req -> DRAIN, old data dropped, next imem_addr=0x200, no inst_valid for old word.
REQ-039 trap_valid and redirect_valid(0x300) same cycle -> imem_addr=0x100, inst_valid cleared.
REQ-040 With FETCH_CTRL_MISALIGN_CHK_EN, redirect_pc=0x202 -> misalign_err 1 cycle, imem_addr=0x100; without it -> imem_addr=0x200.
REQ-041 RESET_VECTOR=32'hFFFF_FFF8, free-running fetch -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - fetch controller bundle: instruction memory, decode hand-off and flush inputs
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        dec_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic        misalign_err;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, misalign_err,
    input  imem_ack, imem_rdata, dec_ready, redirect_valid, redirect_pc, trap_valid
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, misalign_err,
    output imem_ack, imem_rdata, dec_ready, redirect_valid, redirect_pc, trap_valid
  );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch FSM with one-entry skid and flush drain
// Optional FETCH_CTRL_MISALIGN_CHK_EN traps misaligned redirect targets.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic         clk,
  input  logic         rst,
  fetch_ctrl_if.master bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e      state_q;
  logic        req_q;
  logic [31:0] pc_q;
  logic [31:0] pend_pc_q;
  logic        inst_valid_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic [31:0] skid_data_q;
  logic [31:0] skid_pc_q;

  logic        flush;
  logic        slot_free;
  logic [31:0] target;

  assign flush     = bus.trap_valid | bus.redirect_valid;
  assign slot_free = ~inst_valid_q | bus.dec_ready;

`ifdef FETCH_CTRL_MISALIGN_CHK_EN
  logic misalign_d;
  logic misalign_q;

  assign misalign_d = bus.redirect_valid & ~bus.trap_valid & (bus.redirect_pc[1:0] != 2'b00);
  assign target     = (bus.trap_valid | misalign_d) ? TRAP_VECTOR : bus.redirect_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign bus.misalign_err = misalign_q;
`else
  assign target           = bus.trap_valid ? TRAP_VECTOR : (bus.redirect_pc & 32'hFFFF_FFFC);
  assign bus.misalign_err = 1'b0;
`endif

  // STALL always means the skid holds a word, so no separate skid-valid flag is kept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      pc_q         <= RESET_VECTOR;
      pend_pc_q    <= 32'h0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'h0;
      inst_pc_q    <= 32'h0;
      skid_data_q  <= 32'h0;
      skid_pc_q    <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q      <= FETCH;
          req_q        <= 1'b1;
          inst_valid_q <= 1'b0;
          if (flush) pc_q <= target;
        end
        FETCH: begin
          if (flush) begin
            inst_valid_q <= 1'b0;
            if (bus.imem_ack) begin
              pc_q <= target;
            end else begin
              pend_pc_q <= target;
              state_q   <= DRAIN;
            end
          end else if (bus.imem_ack) begin
            pc_q <= pc_q + 32'd4;
            if (slot_free) begin
              inst_q       <= bus.imem_rdata;
              inst_pc_q    <= pc_q;
              inst_valid_q <= 1'b1;
            end else begin
              skid_data_q <= bus.imem_rdata;
              skid_pc_q   <= pc_q;
              state_q     <= STALL;
              req_q       <= 1'b0;
            end
          end else if (bus.dec_ready) begin
            inst_valid_q <= 1'b0;
          end
        end
        STALL: begin
          if (flush) begin
            inst_valid_q <= 1'b0;
            pc_q         <= target;
            state_q      <= FETCH;
            req_q        <= 1'b1;
          end else if (bus.dec_ready) begin
            inst_q    <= skid_data_q;
            inst_pc_q <= skid_pc_q;
            state_q   <= FETCH;
            req_q     <= 1'b1;
          end
        end
        DRAIN: begin
          // The old request stays on the bus until its ack, whose data is dropped.
          inst_valid_q <= 1'b0;
          if (bus.imem_ack) begin
            pc_q    <= flush ? target : pend_pc_q;
            state_q <= FETCH;
          end else if (flush) begin
            pend_pc_q <= target;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench: random memory latency, backpressure and flushes
module tb_fetch_ctrl;
  localparam logic [31:0] TRAP_V = 32'h0000_0100;
  localparam logic [31:0] WRAP_V = 32'hFFFF_FFF8;

  typedef struct {
    logic        flush;
    logic [31:0] target;
    logic        mis;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_ctrl_if bus ();
  fetch_ctrl_if wbus ();

  fetch_ctrl #(.RESET_VECTOR(32'h0), .TRAP_VECTOR(TRAP_V)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fetch_ctrl #(.RESET_VECTOR(WRAP_V), .TRAP_VECTOR(TRAP_V)) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (wbus)
  );

  function automatic logic [31:0] hash(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Free-running zero-wait memory for the wrap-around instance.
  assign wbus.imem_ack       = wbus.imem_req;
  assign wbus.imem_rdata     = hash(wbus.imem_addr);
  assign wbus.dec_ready      = 1'b1;
  assign wbus.redirect_valid = 1'b0;
  assign wbus.redirect_pc    = 32'h0;
  assign wbus.trap_valid     = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int n_cons = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset();
    cmp("rst_req", bus.imem_req, 32'd0);
    cmp("rst_addr", bus.imem_addr, 32'h0);
    cmp("rst_inst_valid", bus.inst_valid, 32'd0);
    cmp("rst_inst", bus.inst, 32'h0);
    cmp("rst_inst_pc", bus.inst_pc, 32'h0);
    cmp("rst_misalign", bus.misalign_err, 32'd0);
    cmp("rst_wrap_addr", wbus.imem_addr, WRAP_V);
  endtask

  // Scoreboard: the driver pushes one item per cycle; the monitor pops and checks the
  // decode stream against the expected program order (sequential pcs, restart at flush target).
  item_t       exp_q[$];
  item_t       it;
  logic        chk_on = 1'b0;
  logic [31:0] exp_pc;
  logic        prev_req, prev_ack, prev_flush, prev_mis;
  logic [31:0] prev_addr;

  always @(negedge clk) begin
    if (chk_on && exp_q.size() > 0) begin
      it = exp_q.pop_front();
      cmp("misalign_err", bus.misalign_err, prev_mis);
      if (prev_flush) cmp("inst_valid_after_flush", bus.inst_valid, 32'd0);
      if (prev_req && !prev_ack) begin
        cmp("addr_hold", bus.imem_addr, prev_addr);
        cmp("req_hold", bus.imem_req, 32'd1);
      end
      if (it.flush) begin
        exp_pc = it.target;
      end else if (bus.inst_valid && bus.dec_ready) begin
        cmp("inst_pc", bus.inst_pc, exp_pc);
        cmp("inst", bus.inst, hash(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_cons++;
      end
      prev_req   = bus.imem_req;
      prev_ack   = bus.imem_ack;
      prev_addr  = bus.imem_addr;
      prev_flush = it.flush;
      prev_mis   = it.mis;
    end
  end

  initial begin
    int          lat;
    int          r;
    logic        trap, redir;
    logic [31:0] rpc;
    item_t       d;

    bus.imem_ack       = 1'b1;
    bus.imem_rdata     = hash(32'h0);
    bus.dec_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.trap_valid     = 1'b0;

    // Reset held with a stray ack present; it must be ignored through IDLE.
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    cmp("idle_req_low", bus.imem_req, 32'd0);

    // Zero-wait memory, decode always ready: one instruction per cycle.
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      cmp("zw_req", bus.imem_req, 32'd1);
      cmp("zw_addr", bus.imem_addr, 32'(4 * k));
      cmp("wrap_addr", wbus.imem_addr, WRAP_V + 32'(4 * k));
      if (k == 0) cmp("zw_first_valid", bus.inst_valid, 32'd0);
      if (k >= 1) begin
        cmp("zw_inst_valid", bus.inst_valid, 32'd1);
        cmp("zw_inst_pc", bus.inst_pc, 32'(4 * (k - 1)));
        cmp("zw_inst", bus.inst, hash(32'(4 * (k - 1))));
        cmp("wrap_inst_pc", wbus.inst_pc, WRAP_V + 32'(4 * (k - 1)));
      end
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = hash(bus.imem_addr);
    end

    // Asynchronous reset in the middle of a fetch, visible without a clock edge.
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset();
    bus.imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst        = 1'b1;
    lat        = 0;
    exp_pc     = 32'h0;
    prev_req   = 1'b0;
    prev_ack   = 1'b0;
    prev_flush = 1'b0;
    prev_mis   = 1'b0;
    prev_addr  = 32'h0;
    chk_on     = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = $urandom;
      if (bus.imem_req) begin
        if (lat == 0) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = hash(bus.imem_addr);
          lat = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
        end else begin
          lat--;
        end
      end
      bus.dec_ready = ($urandom_range(0, 3) != 0);
      r     = int'($urandom_range(0, 15));
      trap  = (r == 0);
      redir = (r == 1) || (r == 2) || ((r == 0) && ($urandom_range(0, 1) == 1));
      rpc   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_0FFC);
      if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      bus.trap_valid     = trap;
      bus.redirect_valid = redir;
      bus.redirect_pc    = rpc;
      d.flush = trap | redir;
      d.mis   = 1'b0;
      if (trap) begin
        d.target = TRAP_V;
      end
`ifdef FETCH_CTRL_MISALIGN_CHK_EN
      else if (rpc[1:0] != 2'b00) begin
        d.target = TRAP_V;
        d.mis    = redir;
      end
`endif
      else begin
        d.target = {rpc[31:2], 2'b00};
      end
      exp_q.push_back(d);
    end

    @(negedge clk);
    #1;
    chk_on = 1'b0;
    cmp("queue_drained", 32'(exp_q.size()), 32'd0);
    cmp("progress", 32'(n_cons > 200), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
